// File: rtl/ace_ctrl_pkg.sv
// Shared opcode, state encodings and sizing helper for the ACE master-port controller.
package ace_ctrl_pkg;

  localparam int unsigned OP_W = 2;

  // Cache request opcodes; OP_RESERVED is rejected with err.
  typedef enum logic [OP_W-1:0] {
    OP_READ_SHARED = 2'd0,
    OP_MAKE_UNIQUE = 2'd1,
    OP_WRITE_CLEAN = 2'd2,
    OP_RESERVED    = 2'd3
  } ace_op_t;

  // Request channel FSM.
  typedef enum logic [2:0] {
    RQ_IDLE = 3'd0,
    RQ_AR   = 3'd1,
    RQ_R    = 3'd2,
    RQ_AW   = 3'd3,
    RQ_W    = 3'd4,
    RQ_B    = 3'd5
  } req_state_t;

  // Snoop channel FSM.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } snoop_state_t;

  // Index width for a counter over n values, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ace_snoop_fsm.sv
// Snoop side of the ACE port: AC accept, tag lookup, CR response and optional CD burst.
module ace_snoop_fsm
  import ace_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned BEAT_W = idx_width(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AC_VALID,
  output logic              AC_READY,
  output logic              CR_VALID,
  input  logic              CR_READY,
  output logic              CD_VALID,
  input  logic              CD_READY,
  output logic              CD_LAST,
  output logic              ac_enable,
  input  logic              snoop_miss,
  input  logic              invalid,
  input  logic              response,
  input  logic              response_data,
  output logic [BEAT_W-1:0] snoop_beat
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  snoop_state_t      state_q, state_d;
  logic              need_q, need_d;
  logic              cr_done_q, cr_done_d;
  logic              cd_done_q, cd_done_d;
  logic [BEAT_W-1:0] sbeat_q, sbeat_d;
  logic              cr_fin, cd_fin;

  // The CR response itself is not encoded here; only the data decision matters.
  logic unused_response;
  assign unused_response = response;

  assign snoop_beat = sbeat_q;

  // State and completion-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      need_q    <= 1'b0;
      cr_done_q <= 1'b0;
      cd_done_q <= 1'b0;
      sbeat_q   <= '0;
    end else begin
      state_q   <= state_d;
      need_q    <= need_d;
      cr_done_q <= cr_done_d;
      cd_done_q <= cd_done_d;
      sbeat_q   <= sbeat_d;
    end
  end

  // Next-state and Moore outputs; CR and CD finish independently.
  always_comb begin
    state_d   = state_q;
    need_d    = need_q;
    cr_done_d = cr_done_q;
    cd_done_d = cd_done_q;
    sbeat_d   = sbeat_q;
    AC_READY  = 1'b0;
    ac_enable = 1'b0;
    CR_VALID  = 1'b0;
    CD_VALID  = 1'b0;
    CD_LAST   = 1'b0;
    cr_fin    = 1'b0;
    cd_fin    = 1'b0;

    case (state_q)
      S_IDLE: begin
        AC_READY = 1'b1;
        if (AC_VALID) begin
          ac_enable = 1'b1;
          state_d   = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        need_d    = response_data & ~(snoop_miss | invalid);
        cr_done_d = 1'b0;
        cd_done_d = ~need_d;
        sbeat_d   = '0;
        state_d   = S_RESP;
      end

      S_RESP: begin
        CR_VALID = ~cr_done_q;
        CD_VALID = need_q & ~cd_done_q;
        CD_LAST  = CD_VALID & (sbeat_q == BEAT_LAST);
        if (CD_VALID && CD_READY) begin
          sbeat_d = (sbeat_q == BEAT_LAST) ? '0 : sbeat_q + BEAT_W'(1);
        end
        cr_fin    = cr_done_q | (CR_VALID & CR_READY);
        cd_fin    = cd_done_q | (CD_VALID & CD_READY & CD_LAST);
        cr_done_d = cr_fin;
        cd_done_d = cd_fin;
        if (cr_fin && cd_fin) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/ace_port_ctrl.sv
// ACE master-port controller: request FSM with bounded retry plus an independent snoop FSM.
module ace_port_ctrl
  import ace_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned BEAT_W = idx_width(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [OP_W-1:0]   op_o,
  output logic [BEAT_W-1:0] beat,
  output logic              read_resp_en,
  input  logic              B_okay,
  input  logic              R_okay,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  input  logic              B_VALID,
  output logic              B_READY,
  output logic              AR_VALID,
  input  logic              AR_READY,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic              R_LAST,
  input  logic              AC_VALID,
  output logic              AC_READY,
  output logic              CR_VALID,
  input  logic              CR_READY,
  output logic              CD_VALID,
  input  logic              CD_READY,
  output logic              CD_LAST,
  output logic              ac_enable,
  input  logic              snoop_miss,
  input  logic              invalid,
  input  logic              response,
  input  logic              response_data,
  output logic [BEAT_W-1:0] snoop_beat
);

  localparam int unsigned       RETRY_W   = idx_width(MAX_RETRY + 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  req_state_t         state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [BEAT_W-1:0]  beat_q, beat_d, beat_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fail_q, fail_d, fail_now;
  logic               done_q, done_d;
  logic               err_q, err_d;

  assign done     = done_q;
  assign err      = err_q;
  assign op_o     = op_q;
  assign beat     = beat_q;
  assign beat_inc = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);

  // Request state, counters and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RQ_IDLE;
      op_q    <= '0;
      beat_q  <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Request next-state; a failed burst retries from its address phase until the limit.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    beat_d       = beat_q;
    retry_d      = retry_q;
    fail_d       = fail_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    fail_now     = 1'b0;
    req_ready    = 1'b0;
    AR_VALID     = 1'b0;
    R_READY      = 1'b0;
    AW_VALID     = 1'b0;
    W_VALID      = 1'b0;
    W_LAST       = 1'b0;
    B_READY      = 1'b0;
    read_resp_en = 1'b0;

    case (state_q)
      RQ_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          retry_d = '0;
          beat_d  = '0;
          fail_d  = 1'b0;
          case (ace_op_t'(req_op))
            OP_READ_SHARED, OP_MAKE_UNIQUE: state_d = RQ_AR;
            OP_WRITE_CLEAN:                 state_d = RQ_AW;
            default:                        err_d   = 1'b1;
          endcase
        end
      end

      RQ_AR: begin
        AR_VALID = 1'b1;
        if (AR_READY) state_d = RQ_R;
      end

      RQ_R: begin
        R_READY = 1'b1;
        if (R_VALID) begin
          read_resp_en = 1'b1;
          beat_d       = beat_inc;
          fail_now     = fail_q | ~R_okay;
          fail_d       = fail_now;
          if (R_LAST) begin
            if (!fail_now) begin
              done_d  = 1'b1;
              state_d = RQ_IDLE;
            end else if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + RETRY_W'(1);
              beat_d  = '0;
              fail_d  = 1'b0;
              state_d = RQ_AR;
            end else begin
              err_d   = 1'b1;
              state_d = RQ_IDLE;
            end
          end
        end
      end

      RQ_AW: begin
        AW_VALID = 1'b1;
        if (AW_READY) state_d = RQ_W;
      end

      RQ_W: begin
        W_VALID = 1'b1;
        W_LAST  = (beat_q == BEAT_LAST);
        if (W_READY) begin
          beat_d = beat_inc;
          if (W_LAST) state_d = RQ_B;
        end
      end

      RQ_B: begin
        B_READY = 1'b1;
        if (B_VALID) begin
          fail_now = ~B_okay;
          if (!fail_now) begin
            done_d  = 1'b1;
            state_d = RQ_IDLE;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_W'(1);
            beat_d  = '0;
            fail_d  = 1'b0;
            state_d = RQ_AW;
          end else begin
            err_d   = 1'b1;
            state_d = RQ_IDLE;
          end
        end
      end

      default: state_d = RQ_IDLE;
    endcase
  end

  // Snoop channels run on their own FSM, decoupled from request traffic.
  ace_snoop_fsm #(
    .BURST_LEN(BURST_LEN)
  ) u_snoop (
    .clk          (clk),
    .rst_n        (rst_n),
    .AC_VALID     (AC_VALID),
    .AC_READY     (AC_READY),
    .CR_VALID     (CR_VALID),
    .CR_READY     (CR_READY),
    .CD_VALID     (CD_VALID),
    .CD_READY     (CD_READY),
    .CD_LAST      (CD_LAST),
    .ac_enable    (ac_enable),
    .snoop_miss   (snoop_miss),
    .invalid      (invalid),
    .response     (response),
    .response_data(response_data),
    .snoop_beat   (snoop_beat)
  );

endmodule

// File: tb/tb_ace_port_ctrl.sv
// Directed bench for ace_port_ctrl at BURST_LEN=4, MAX_RETRY=3.
module tb_ace_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, done, err, read_resp_en;
  logic [1:0] req_op, op_o, beat, snoop_beat;
  logic       B_okay, R_okay;
  logic       AW_VALID, AW_READY, W_VALID, W_READY, W_LAST, B_VALID, B_READY;
  logic       AR_VALID, AR_READY, R_VALID, R_READY, R_LAST;
  logic       AC_VALID, AC_READY, CR_VALID, CR_READY, CD_VALID, CD_READY, CD_LAST;
  logic       ac_enable, snoop_miss, invalid, response, response_data;

  int checks   = 0;
  int failures = 0;
  int aw_hs    = 0;

  always #5 clk = ~clk;

  ace_port_ctrl #(.BURST_LEN(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .done(done), .err(err), .op_o(op_o), .beat(beat), .read_resp_en(read_resp_en),
    .B_okay(B_okay), .R_okay(R_okay),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .W_VALID(W_VALID), .W_READY(W_READY),
    .W_LAST(W_LAST), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .R_VALID(R_VALID), .R_READY(R_READY),
    .R_LAST(R_LAST),
    .AC_VALID(AC_VALID), .AC_READY(AC_READY), .CR_VALID(CR_VALID), .CR_READY(CR_READY),
    .CD_VALID(CD_VALID), .CD_READY(CD_READY), .CD_LAST(CD_LAST),
    .ac_enable(ac_enable), .snoop_miss(snoop_miss), .invalid(invalid),
    .response(response), .response_data(response_data), .snoop_beat(snoop_beat)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; B_okay = 1'b0; R_okay = 1'b0;
    AR_READY = 1'b0; R_VALID = 1'b0; R_LAST = 1'b0; AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b0; AC_VALID = 1'b0; CR_READY = 1'b0; CD_READY = 1'b0;
    snoop_miss = 1'b0; invalid = 1'b0; response = 1'b0; response_data = 1'b0;

    // Reset values
    #2;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_ac_ready", AC_READY, 1'b1);
    chk1("rst_ar_valid", AR_VALID, 1'b0);
    chk1("rst_aw_valid", AW_VALID, 1'b0);
    chk1("rst_w_valid", W_VALID, 1'b0);
    chk1("rst_cr_valid", CR_VALID, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkn("rst_beat", 32'(beat), 32'd0);
    chkn("rst_snoop_beat", 32'(snoop_beat), 32'd0);
    chkn("rst_op", 32'(op_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // READ_SHARED with AR stalled two cycles, one R gap before beat 2
    req_valid = 1'b1; req_op = 2'd0; #1;
    chk1("rs_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; AR_READY = 1'b0; #1;
    chk1("rs_ar_c1", AR_VALID, 1'b1);
    chk1("rs_req_busy", req_ready, 1'b0);
    tick();
    #1; chk1("rs_ar_c2", AR_VALID, 1'b1);
    tick();
    AR_READY = 1'b1; #1;
    chk1("rs_ar_c3", AR_VALID, 1'b1);
    tick();
    AR_READY = 1'b0; #1;
    chk1("rs_ar_drop", AR_VALID, 1'b0);
    chk1("rs_r_ready", R_READY, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        R_VALID = 1'b0; R_LAST = 1'b0; #1;
        chk1("rs_gap_resp_en", read_resp_en, 1'b0);
        chkn("rs_gap_beat", 32'(beat), 32'd2);
        tick();
      end
      R_VALID = 1'b1; R_okay = 1'b1; R_LAST = (i == 3); #1;
      chk1("rs_resp_en", read_resp_en, 1'b1);
      chkn("rs_beat", 32'(beat), i);
      chk1("rs_no_early_done", done, 1'b0);
      tick();
    end
    R_VALID = 1'b0; R_LAST = 1'b0; #1;
    chk1("rs_done", done, 1'b1);
    chk1("rs_done_ready", req_ready, 1'b1);
    chkn("rs_beat_wrap", 32'(beat), 32'd0);
    tick();
    #1; chk1("rs_done_pulse", done, 1'b0);

    // WRITE_CLEAN with W_READY toggling
    req_valid = 1'b1; req_op = 2'd2; #1;
    tick();
    req_valid = 1'b0; AW_READY = 1'b1; #1;
    chk1("wc_aw_valid", AW_VALID, 1'b1);
    chkn("wc_op", 32'(op_o), 32'd2);
    tick();
    AW_READY = 1'b0;
    for (int k = 0; k < 7; k++) begin
      W_READY = (k % 2 == 0); #1;
      chk1("wc_w_valid", W_VALID, 1'b1);
      chkn("wc_beat", 32'(beat), (k + 1) / 2);
      chk1("wc_w_last", W_LAST, ((k + 1) / 2 == 3));
      chk1("wc_b_ready_early", B_READY, 1'b0);
      tick();
    end
    W_READY = 1'b0; #1;
    chk1("wc_b_ready", B_READY, 1'b1);
    chk1("wc_w_done", W_VALID, 1'b0);
    tick();
    B_VALID = 1'b1; B_okay = 1'b1; #1;
    chk1("wc_b_ready2", B_READY, 1'b1);
    chk1("wc_no_early_done", done, 1'b0);
    tick();
    B_VALID = 1'b0;
    // Back-to-back accept of a reserved opcode in the done cycle
    req_valid = 1'b1; req_op = 2'd3; #1;
    chk1("wc_done", done, 1'b1);
    chk1("wc_b2b_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; #1;
    chk1("rsv_err", err, 1'b1);
    chk1("rsv_idle", req_ready, 1'b1);
    chk1("rsv_no_aw", AW_VALID, 1'b0);
    chk1("rsv_no_ar", AR_VALID, 1'b0);
    chk1("rsv_no_done", done, 1'b0);
    tick();
    #1; chk1("rsv_err_pulse", err, 1'b0);

    // WRITE_CLEAN failing on B four times exhausts retries
    req_valid = 1'b1; req_op = 2'd2; #1;
    tick();
    req_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      AW_READY = 1'b1; #1;
      chk1("rt_aw_valid", AW_VALID, 1'b1);
      chk1("rt_no_done", done, 1'b0);
      chk1("rt_no_err", err, 1'b0);
      chkn("rt_beat_clear", 32'(beat), 32'd0);
      if (AW_VALID && AW_READY) aw_hs++;
      tick();
      AW_READY = 1'b0;
      for (int j = 0; j < 4; j++) begin
        W_READY = 1'b1; #1;
        chkn("rt_w_beat", 32'(beat), j);
        tick();
      end
      W_READY = 1'b0; B_VALID = 1'b1; B_okay = 1'b0; #1;
      chk1("rt_b_ready", B_READY, 1'b1);
      tick();
      B_VALID = 1'b0;
    end
    #1;
    chk1("rt_err", err, 1'b1);
    chk1("rt_final_no_done", done, 1'b0);
    chk1("rt_no_more_aw", AW_VALID, 1'b0);
    chk1("rt_idle", req_ready, 1'b1);
    chkn("rt_aw_count", aw_hs, 32'd4);
    tick();

    // Snoop hit with data, CR immediate, CD stalled one cycle per beat
    AC_VALID = 1'b1; #1;
    chk1("sn_ac_ready", AC_READY, 1'b1);
    chk1("sn_ac_enable", ac_enable, 1'b1);
    tick();
    AC_VALID = 1'b0; response = 1'b1; response_data = 1'b1; snoop_miss = 1'b0; invalid = 1'b0; #1;
    chk1("sn_lookup_ac_ready", AC_READY, 1'b0);
    chk1("sn_lookup_ac_en", ac_enable, 1'b0);
    chk1("sn_lookup_cr", CR_VALID, 1'b0);
    tick();
    response = 1'b0; response_data = 1'b0; CR_READY = 1'b1; CD_READY = 1'b0; #1;
    chk1("sn_cr_valid", CR_VALID, 1'b1);
    chk1("sn_cd_valid", CD_VALID, 1'b1);
    chk1("sn_cd_last0", CD_LAST, 1'b0);
    tick();
    CR_READY = 1'b0; CD_READY = 1'b1; #1;
    chk1("sn_cr_done", CR_VALID, 1'b0);
    chkn("sn_beat0", 32'(snoop_beat), 32'd0);
    tick();
    for (int b = 1; b < 4; b++) begin
      CD_READY = 1'b0; #1;
      chk1("sn_stall_cd_valid", CD_VALID, 1'b1);
      chkn("sn_stall_beat", 32'(snoop_beat), b);
      chk1("sn_stall_last", CD_LAST, (b == 3));
      tick();
      CD_READY = 1'b1; #1;
      chk1("sn_cd_last", CD_LAST, (b == 3));
      chk1("sn_busy", AC_READY, 1'b0);
      tick();
    end
    CD_READY = 1'b0; #1;
    chk1("sn_back_idle", AC_READY, 1'b1);
    chk1("sn_cd_off", CD_VALID, 1'b0);
    chkn("sn_beat_wrap", 32'(snoop_beat), 32'd0);
    tick();

    // Request and snoop accepted together, snoop miss completes during the R burst
    req_valid = 1'b1; req_op = 2'd0; AC_VALID = 1'b1; #1;
    chk1("cc_req_ready", req_ready, 1'b1);
    chk1("cc_ac_enable", ac_enable, 1'b1);
    tick();
    req_valid = 1'b0; AC_VALID = 1'b0; AR_READY = 1'b1;
    snoop_miss = 1'b1; response_data = 1'b1; #1;
    chk1("cc_ar_valid", AR_VALID, 1'b1);
    chk1("cc_lookup", AC_READY, 1'b0);
    tick();
    AR_READY = 1'b0; snoop_miss = 1'b0; response_data = 1'b0;
    R_VALID = 1'b1; R_okay = 1'b1; R_LAST = 1'b0; CR_READY = 1'b0; #1;
    chk1("cc_r0", read_resp_en, 1'b1);
    chk1("cc_cr_valid", CR_VALID, 1'b1);
    chk1("cc_miss_no_cd", CD_VALID, 1'b0);
    tick();
    CR_READY = 1'b1; #1;
    chkn("cc_beat1", 32'(beat), 32'd1);
    chk1("cc_cr_hs", CR_VALID, 1'b1);
    tick();
    CR_READY = 1'b0; #1;
    chkn("cc_beat2", 32'(beat), 32'd2);
    chk1("cc_snoop_idle", AC_READY, 1'b1);
    chk1("cc_cr_gone", CR_VALID, 1'b0);
    tick();
    R_LAST = 1'b1; #1;
    chkn("cc_beat3", 32'(beat), 32'd3);
    tick();
    R_VALID = 1'b0; R_LAST = 1'b0; #1;
    chk1("cc_done", done, 1'b1);
    tick();

    // MAKE_UNIQUE short response: failed single beat retries AR, then succeeds
    req_valid = 1'b1; req_op = 2'd1; #1;
    tick();
    req_valid = 1'b0; AR_READY = 1'b1; #1;
    chkn("mu_op", 32'(op_o), 32'd1);
    tick();
    AR_READY = 1'b0; R_VALID = 1'b1; R_LAST = 1'b1; R_okay = 1'b0; #1;
    chk1("mu_resp_en", read_resp_en, 1'b1);
    tick();
    R_VALID = 1'b0; R_LAST = 1'b0; AR_READY = 1'b1; #1;
    chk1("mu_retry_ar", AR_VALID, 1'b1);
    chk1("mu_retry_no_err", err, 1'b0);
    chk1("mu_retry_no_done", done, 1'b0);
    chkn("mu_retry_beat", 32'(beat), 32'd0);
    tick();
    AR_READY = 1'b0; R_VALID = 1'b1; R_LAST = 1'b1; R_okay = 1'b1; #1;
    tick();
    R_VALID = 1'b0; R_LAST = 1'b0; #1;
    chk1("mu_done", done, 1'b1);
    chk1("mu_no_err", err, 1'b0);
    tick();

    // Reset asserted during W beat 2
    req_valid = 1'b1; req_op = 2'd2; #1;
    tick();
    req_valid = 1'b0; AW_READY = 1'b1; #1;
    tick();
    AW_READY = 1'b0; W_READY = 1'b1; #1;
    tick();
    #1;
    tick();
    W_READY = 1'b0; #1;
    chkn("rw_beat2", 32'(beat), 32'd2);
    chk1("rw_w_valid", W_VALID, 1'b1);
    rst_n = 1'b0; #1;
    chk1("rw_w_off", W_VALID, 1'b0);
    chk1("rw_req_ready", req_ready, 1'b1);
    chkn("rw_beat", 32'(beat), 32'd0);
    chkn("rw_op", 32'(op_o), 32'd0);
    chk1("rw_ac_ready", AC_READY, 1'b1);
    chk1("rw_done", done, 1'b0);
    tick();
    rst_n = 1'b1; #1;
    chk1("rw_rel_ready", req_ready, 1'b1);
    chk1("rw_rel_aw", AW_VALID, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
